// File: rtl/curl_round_ctrl.sv
// curl_round_ctrl: Curl-P transform sequencer over a 729-trit sponge state, one full-state round per clock.
// Latency: busy for NUM_ROUNDS cycles after start, then a one-cycle done pulse; word reads return 1 cycle after rd_en.
// Backpressure: none; writes outside IDLE are dropped and flagged on wr_err, a start outside IDLE is ignored.
// Optional build macro CURL_STATE_CLEAR_EN adds a 'clear' input that zeroes the state in IDLE.
module curl_round_ctrl #(
   parameter int NUM_ROUNDS = 81,
   parameter int WORD_TRITS = 27
) (
   input  logic                    clk,
   input  logic                    reset,
`ifdef CURL_STATE_CLEAR_EN
   input  logic                    clear,
`endif
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   input  logic                    wr_en,
   input  logic                    rd_en,
   input  logic [4:0]              addr,
   input  logic [2*WORD_TRITS-1:0] wdata,
   output logic [2*WORD_TRITS-1:0] rdata,
   output logic                    wr_err
);

   localparam int NUM_WORDS   = 27;
   localparam int WORD_BITS   = 2 * WORD_TRITS;
   localparam int STATE_TRITS = NUM_WORDS * WORD_TRITS;
   localparam int STATE_BITS  = 2 * STATE_TRITS;
   // Lane k reads trit (STEP*k) mod N; STEP = (N-1)/2 gives the Curl-P shuffle.
   localparam int PERM_STEP   = (STATE_TRITS - 1) / 2;
   localparam logic [6:0] LAST_CNT = 7'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fsm_t;

   fsm_t                  fsm_q;
   fsm_t                  fsm_nxt;
   logic [6:0]            round_cnt;
   logic [STATE_BITS-1:0] st;
   logic [STATE_BITS-1:0] st_nxt;
   logic [STATE_BITS-1:0] round_st;
   logic [WORD_BITS-1:0]  wr_word;
   logic [WORD_BITS-1:0]  rd_word;
   logic                  addr_ok;
   logic                  in_idle;
   logic                  clear_req;
   logic                  wr_ok;
   logic                  go;

   // Trit code (11/00/01) to offset 0/1/2, i.e. value + 1.
   function automatic logic [3:0] trit_ofs(input logic [1:0] t);
      logic [3:0] r;
      case (t)
         2'b11:   r = 4'd0;
         2'b01:   r = 4'd2;
         default: r = 4'd1;
      endcase
      return r;
   endfunction

   // Curl-P substitution box indexed by (a+1) + 3*(b+1).
   function automatic logic [1:0] trit_tt(input logic [1:0] a, input logic [1:0] b);
      logic [3:0] sel;
      logic [1:0] r;
      sel = trit_ofs(a) + 4'd3 * trit_ofs(b);
      case (sel)
         4'd0:    r = 2'b01;
         4'd1:    r = 2'b00;
         4'd2:    r = 2'b11;
         4'd3:    r = 2'b01;
         4'd4:    r = 2'b11;
         4'd5:    r = 2'b00;
         4'd6:    r = 2'b11;
         4'd7:    r = 2'b01;
         4'd8:    r = 2'b00;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // One truth-table lane per trit; the shuffle indices fold to constants at elaboration.
   for (genvar i = 0; i < STATE_TRITS; i++) begin : g_lane
      localparam int PA = (PERM_STEP * i) % STATE_TRITS;
      localparam int PB = (PERM_STEP * (i + 1)) % STATE_TRITS;
      assign round_st[2*i +: 2] = trit_tt(st[2*PA +: 2], st[2*PB +: 2]);
   end

   assign addr_ok = (addr < 5'(NUM_WORDS));
   assign in_idle = (fsm_q == S_IDLE);

`ifdef CURL_STATE_CLEAR_EN
   // Clear only acts in IDLE and swallows any same-cycle write or start.
   assign clear_req = clear & in_idle;
`else
   assign clear_req = 1'b0;
`endif

   assign wr_ok = wr_en & addr_ok & in_idle & ~clear_req;
   assign go    = start & in_idle & ~clear_req;

   // Write data with the unused code 10 forced to 00 so the state never holds it.
   always_comb begin
      wr_word = '0;
      for (int j = 0; j < WORD_TRITS; j++) begin
         wr_word[2*j +: 2] = (wdata[2*j +: 2] == 2'b10) ? 2'b00 : wdata[2*j +: 2];
      end
   end

   // Read word mux; out-of-range addresses return zero.
   always_comb begin
      rd_word = '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         if (addr == 5'(w)) begin
            rd_word = st[w*WORD_BITS +: WORD_BITS];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q <= S_IDLE;
      end else begin
         fsm_q <= fsm_nxt;
      end
   end

   // FSM next-state: the last round is applied on the edge that enters DONE.
   always_comb begin
      fsm_nxt = fsm_q;
      case (fsm_q)
         S_IDLE:  if (go) fsm_nxt = S_RUN;
         S_RUN:   if (round_cnt == LAST_CNT) fsm_nxt = S_DONE;
         S_DONE:  fsm_nxt = S_IDLE;
         default: fsm_nxt = S_IDLE;
      endcase
   end

   // FSM outputs decoded straight from the state register.
   always_comb begin
      busy = (fsm_q == S_RUN);
      done = (fsm_q == S_DONE);
   end

   // Round counter: cleared on start, bumped once per applied round; 7 bits cover 127 rounds.
   always_ff @(posedge clk) begin
      if (reset) begin
         round_cnt <= '0;
      end else if (go) begin
         round_cnt <= '0;
      end else if (fsm_q == S_RUN) begin
         round_cnt <= round_cnt + 7'd1;
      end
   end

   // Next sponge state: a round while running, otherwise host clear or word write.
   always_comb begin
      st_nxt = st;
      if (fsm_q == S_RUN) begin
         st_nxt = round_st;
      end else if (clear_req) begin
         st_nxt = '0;
      end else if (wr_ok) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            if (addr == 5'(w)) begin
               st_nxt[w*WORD_BITS +: WORD_BITS] = wr_word;
            end
         end
      end
   end

   // Sponge state register; reset also aborts an in-flight transform's data.
   always_ff @(posedge clk) begin
      if (reset) begin
         st <= '0;
      end else begin
         st <= st_nxt;
      end
   end

   // Registered read port; holds the last word while rd_en is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= rd_word;
      end
   end

   // Flag in-range writes that arrive while a transform owns the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en & addr_ok & ~in_idle;
      end
   end

endmodule

// File: tb/tb_curl_round_ctrl.sv
// tb_curl_round_ctrl: random state loads and transforms checked against a trit-array Curl-P model.
// Expected reads, done and wr_err events are queued by stimulus and popped by a negedge monitor.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_curl_round_ctrl;

   localparam int NR = 81;
   localparam int NW = 27;
   localparam int WT = 27;
   localparam int NT = NW * WT;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        wr_en;
   logic        rd_en;
   logic [4:0]  addr;
   logic [53:0] wdata;
   logic [53:0] rdata;
   logic        wr_err;
`ifdef CURL_STATE_CLEAR_EN
   logic        clear;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   int model[NT];
   int ttv[9] = '{1, 0, -1, 1, -1, 0, -1, 1, 0};

   logic [53:0] rd_q[$];
   int          done_q[$];
   int          err_q[$];
   logic        rd_d  = 1'b0;
   logic        rst_d = 1'b0;
   logic [53:0] last_rd = '0;

   curl_round_ctrl #(.NUM_ROUNDS(NR), .WORD_TRITS(WT)) dut (
      .clk    (clk),
      .reset  (reset),
`ifdef CURL_STATE_CLEAR_EN
      .clear  (clear),
`endif
      .start  (start),
      .busy   (busy),
      .done   (done),
      .wr_en  (wr_en),
      .rd_en  (rd_en),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .wr_err (wr_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rd_d  <= rd_en;
      rst_d <= reset;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int dec(input logic [1:0] t);
      if (t == 2'b01) return 1;
      if (t == 2'b11) return -1;
      return 0;
   endfunction

   function automatic logic [53:0] enc_word(input int w);
      logic [53:0] r;
      r = '0;
      for (int j = 0; j < WT; j++) begin
         case (model[w*WT + j])
            1:       r[2*j +: 2] = 2'b01;
            -1:      r[2*j +: 2] = 2'b11;
            default: r[2*j +: 2] = 2'b00;
         endcase
      end
      return r;
   endfunction

   task automatic model_write(input int a, input logic [53:0] d);
      if (a < NW) begin
         for (int j = 0; j < WT; j++) model[a*WT + j] = dec(d[2*j +: 2]);
      end
   endtask

   task automatic model_round();
      int nw[NT];
      int a;
      int b;
      for (int i = 0; i < NT; i++) begin
         a = model[(364 * i) % NT];
         b = model[(364 * (i + 1)) % NT];
         nw[i] = ttv[(a + 1) + 3 * (b + 1)];
      end
      model = nw;
   endtask

   task automatic model_zero();
      for (int i = 0; i < NT; i++) model[i] = 0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin : mon
      logic [53:0] e;
      int          c;
      if (mon_en) begin
         if (rst_d) begin
            chk("rdata_after_reset", rdata, 54'd0);
            last_rd = '0;
         end else if (rd_d) begin
            if (rd_q.size() == 0) begin
               chk("rd_unexpected", 64'd1, 64'd0);
            end else begin
               e = rd_q.pop_front();
               chk("rdata", rdata, e);
               last_rd = e;
            end
         end else begin
            chk("rdata_hold", rdata, last_rd);
         end
         if (done) begin
            if (done_q.size() == 0) chk("done_spurious", 64'(cyc), 64'hFFFF_FFFF);
            else begin
               c = done_q.pop_front();
               chk("done_cycle", 64'(cyc), 64'(c));
            end
         end
         if (wr_err) begin
            if (err_q.size() == 0) chk("wr_err_spurious", 64'(cyc), 64'hFFFF_FFFF);
            else begin
               c = err_q.pop_front();
               chk("wr_err_cycle", 64'(cyc), 64'(c));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [53:0] rand_word();
      return 54'({$urandom(), $urandom()});
   endfunction

   task automatic do_write(input int a, input logic [53:0] d);
      wr_en = 1'b1;
      addr  = 5'(a);
      wdata = d;
      tick();
      wr_en = 1'b0;
      model_write(a, d);
   endtask

   task automatic do_read(input int a);
      rd_en = 1'b1;
      addr  = 5'(a);
      rd_q.push_back(a < NW ? enc_word(a) : 54'd0);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic read_all();
      for (int w = 0; w < NW; w++) do_read(w);
   endtask

   task automatic load_random();
      for (int w = 0; w < NW; w++) do_write(w, rand_word());
   endtask

   // Run one transform; optional mid-run read, rejected write, extra start, reset abort,
   // or a write issued together with start.
   task automatic run_transform(input int rd_round, input bit bad_write, input bit extra_start,
                                input int rst_round, input int wr_with_start);
      int x;
      start = 1'b1;
      if (wr_with_start >= 0) begin
         wr_en = 1'b1;
         addr  = 5'(wr_with_start);
         wdata = rand_word();
         model_write(wr_with_start, wdata);
      end
      x = cyc;
      done_q.push_back(x + 1 + NR);
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      for (int r = 0; r < NR; r++) begin
         if (r == 0 || r == NR - 1) begin
            chk("busy_in_run", busy, 1);
            chk("done_in_run", done, 0);
         end
         if (r == rd_round) begin
            rd_en = 1'b1;
            addr  = 5'($urandom_range(0, NW - 1));
            rd_q.push_back(enc_word(int'(addr)));
         end
         if (bad_write && r == 3) begin
            wr_en = 1'b1;
            addr  = 5'd5;
            wdata = rand_word();
            err_q.push_back(cyc + 1);
         end
         if (extra_start && r == 5) start = 1'b1;
         if (r == rst_round) reset = 1'b1;
         tick();
         rd_en = 1'b0;
         wr_en = 1'b0;
         start = 1'b0;
         if (r == rst_round) begin
            reset = 1'b0;
            chk("busy_after_abort", busy, 0);
            chk("done_after_abort", done, 0);
            void'(done_q.pop_back());
            model_zero();
            return;
         end
         model_round();
      end
      chk("busy_in_done", busy, 0);
      tick();
      chk("busy_after_done", busy, 0);
      chk("done_after_done", done, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset = 1'b1;
      start = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      addr  = '0;
      wdata = '0;
`ifdef CURL_STATE_CLEAR_EN
      clear = 1'b0;
`endif
      model_zero();
      tick();
      mon_en = 1'b1;
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_wr_err", wr_err, 0);
      chk("reset_rdata", rdata, 0);
      reset = 1'b0;
      tick();
      read_all();

      // All-zero state: intermediate read after one round, period-3 return to zero.
      run_transform(1, 1'b0, 1'b0, -1, -1);
      read_all();

      // Random state (with 10 codes sanitised), rejected write to word 5, ignored second start.
      load_random();
      read_all();
      run_transform($urandom_range(0, NR - 1), 1'b1, 1'b1, -1, -1);
      read_all();
      repeat (NR + 5) tick();

      // Single +1 at trit 0.
      for (int w = 0; w < NW; w++) do_write(w, (w == 0) ? 54'd1 : 54'd0);
      run_transform(2, 1'b0, 1'b0, -1, -1);
      read_all();

      // Write and start in the same cycle: transform starts from the written word.
      load_random();
      run_transform(-1, 1'b0, 1'b0, -1, $urandom_range(0, NW - 1));
      read_all();

      // Out-of-range reads and silently dropped out-of-range writes.
      do_read(27);
      do_read(31);
      do_write(28, rand_word());
      do_write(31, rand_word());
      read_all();

      // Reset at round 40 aborts and clears; a fresh transform then completes.
      run_transform(-1, 1'b0, 1'b0, 40, -1);
      read_all();
      do_write(7, rand_word());
      run_transform(10, 1'b0, 1'b0, -1, -1);
      read_all();

`ifdef CURL_STATE_CLEAR_EN
      // Clear beats a simultaneous start and write.
      load_random();
      clear = 1'b1;
      start = 1'b1;
      wr_en = 1'b1;
      addr  = 5'd3;
      wdata = rand_word();
      tick();
      clear = 1'b0;
      start = 1'b0;
      wr_en = 1'b0;
      model_zero();
      chk("clear_busy", busy, 0);
      tick();
      chk("clear_busy_2", busy, 0);
      read_all();
`endif

      repeat (20) tick();
      chk("done_q_drained", 64'(done_q.size()), 0);
      chk("err_q_drained", 64'(err_q.size()), 0);
      chk("rd_q_drained", 64'(rd_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
